// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier for signed or unsigned operands.
// Takes one Booth step per cycle over WIDTH+1 extended bits.
// The result is registered on the last step and held until the next completion.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [EW-1:0] acc;
  logic [EW-1:0] q;
  logic [EW-1:0] m;
  logic          q_m1;
  logic [CW-1:0] cnt;

  logic [EW-1:0] ext_a;
  logic [EW-1:0] ext_b;
  logic [EW-1:0] acc_op;
  logic [EW-1:0] acc_sh;
  logic [EW-1:0] q_sh;
  logic          last;

  // Operand extension, then one Booth add/sub followed by the arithmetic right shift
  always_comb begin
    ext_a  = {signed_mode & a[WIDTH-1], a};
    ext_b  = {signed_mode & b[WIDTH-1], b};
    acc_op = acc;
    case ({q[0], q_m1})
      2'b01:   acc_op = acc + m;
      2'b10:   acc_op = acc - m;
      default: acc_op = acc;
    endcase
    acc_sh = {acc_op[EW-1], acc_op[EW-1:1]};
    q_sh   = {acc_op[0], q[EW-1:1]};
    last   = (state == CALC) && (cnt == CW'(WIDTH));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are pure decodes of the state register
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      CALC:    busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Working registers: load on accepted start, step in CALC, capture result on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      m    <= '0;
      cnt  <= '0;
      prod <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            q    <= ext_b;
            q_m1 <= 1'b0;
            m    <= ext_a;
            cnt  <= '0;
          end
        end
        CALC: begin
          acc  <= acc_sh;
          q    <= q_sh;
          q_m1 <= q[0];
          cnt  <= cnt + CW'(1);
          if (last) prod <= {acc_sh[WIDTH-2:0], q_sh};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8): directed corners plus a random regression
// against a plain-arithmetic product model.
`timescale 1ns/1ps
module tb_booth_mult_seq;

  localparam int unsigned W = 8;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;

  int total = 0;
  int bad   = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .prod(prod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference product: true integer product of the interpreted operands, truncated to 2W bits
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    longint sx;
    longint sy;
    sx = sm ? longint'($signed(x)) : longint'(x);
    sy = sm ? longint'($signed(y)) : longint'(y);
    return (2*W)'(sx * sy);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One multiply: wait for ready, pulse start, measure latency to done, check result and hold
  task automatic run_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sm, input bit toggle);
    logic [2*W-1:0] p0;
    logic [2*W-1:0] exp_p;
    bit ok;
    int lat;
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin
      step();
      guard++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
    exp_p = ref_prod(x, y, sm);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    step();
    start = 1'b0;
    p0 = prod;
    ok = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (toggle) begin
        a = W'($urandom); b = W'($urandom);
        start = 1'($urandom); signed_mode = 1'($urandom);
      end
      step();
      if (done) begin
        lat = n;
        break;
      end
      if (prod !== p0 || busy !== 1'b1 || ready !== 1'b0) ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_prod"}, 32'(prod), 32'(exp_p));
    check({tag, "_hold"}, 32'(ok), 32'd1);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] corners [5];
    logic [W-1:0] x;
    logic [W-1:0] y;
    int dq[$];
    int last_done;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_prod",  32'(prod),  32'd0);
    rst = 1'b0;

    // First edge after reset release carries the start
    run_mul("neg128sq", 8'h80, 8'h80, 1'b1, 1'b0);
    check("neg128sq_val", 32'(prod), 32'h4000);
    run_mul("u255sq", 8'hFF, 8'hFF, 1'b0, 1'b0);
    check("u255sq_val", 32'(prod), 32'hFE01);
    run_mul("m1sq", 8'hFF, 8'hFF, 1'b1, 1'b0);
    check("m1sq_val", 32'(prod), 32'h0001);
    run_mul("m1x127", 8'hFF, 8'h7F, 1'b1, 1'b0);
    check("m1x127_val", 32'(prod), 32'hFF81);
    run_mul("zero", 8'h00, 8'h5A, 1'b1, 1'b0);
    check("zero_val", 32'(prod), 32'h0000);

    // Inputs churn during CALC; only the sampled operands matter
    run_mul("toggle", 8'h37, 8'h29, 1'b0, 1'b1);
    check("toggle_val", 32'(prod), 32'h08CF);
    step();
    check("toggle_one_done", 32'(done), 32'd0);

    // Abort in the 4th CALC cycle
    a = 8'h55; b = 8'h33; signed_mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_prod",  32'(prod),  32'd0);
    run_mul("after_abort", 8'd3, 8'd5, 1'b0, 1'b0);
    check("after_abort_val", 32'(prod), 32'h000F);

    // start held high: back-to-back multiplies
    step();
    a = 8'd7; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
    last_done = -100;
    for (int cyc = 0; cyc <= 33; cyc++) begin
      step();
      if (cyc == last_done + 1) begin
        check("b2b_gap_ready", 32'(ready), 32'd1);
        check("b2b_gap_busy",  32'(busy),  32'd0);
      end
      if (cyc == last_done + 2) check("b2b_next_busy", 32'(busy), 32'd1);
      if (done) begin
        check("b2b_prod", 32'(prod), 32'h003F);
        last_done = cyc;
        dq.push_back(cyc);
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(dq.size()), 32'd3);
    if (dq.size() == 3) begin
      check("b2b_first", 32'(dq[0]), 32'(LAT));
      check("b2b_period1", 32'(dq[1] - dq[0]), 32'd11);
      check("b2b_period2", 32'(dq[2] - dq[1]), 32'd11);
    end

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(7) == 0) x = corners[$urandom_range(4)];
      if ($urandom_range(7) == 0) y = corners[$urandom_range(4)];
      run_mul("rnd", x, y, 1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  Request to begin a multiply; it is sampled only in IDLE.
REQ-005 signed_mode  input  1  Operand interpretation: 1 = two's complement, 0 = unsigned; sampled together with start.
REQ-006 a  input  WIDTH  Multiplicand; sampled together with start.
REQ-007 b  input  WIDTH  Multiplier; sampled together with start.
REQ-008 ready  output  1  High exactly when the state is IDLE.
REQ-009 busy  output  1  High exactly when the state is CALC.
REQ-010 done  output  1  One-cycle pulse, high exactly when the state is DONE.
REQ-011 prod  output  2*WIDTH  Registered result of the last completed multiply.

Function
REQ-012 The FSM SHALL have three states, IDLE, CALC and DONE, with the following transitions:
- IDLE -> CALC when start=1.
- CALC -> DONE on the final iteration.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 On the start edge, a and b SHALL be extended to WIDTH+1 bits: sign-extended when signed_mode=1, zero-extended when signed_mode=0.
REQ-014 On the start edge the block SHALL also load its working registers:
- accumulator A (WIDTH+1 bits) = 0;
- Q = extended b;
- q_m1 = 0;
- M = extended a;
- iteration counter = 0.
REQ-015 Each CALC cycle SHALL perform one radix-2 Booth step on {Q[0], q_m1}:
- 01: A = A + M;
- 10: A = A - M;
- 00 or 11: A unchanged.
This is followed by an arithmetic right shift of {A, Q, q_m1} by one bit.
REQ-016 All accumulator arithmetic SHALL be performed modulo 2^(WIDTH+1), with sign preserved on the shift.
REQ-017 CALC SHALL last exactly WIDTH+1 cycles (one per extended bit); the counter SHALL be wide enough to reach WIDTH+1 without wrap.
REQ-018 On the edge that completes the last step, the block SHALL:
- load prod with the low 2*WIDTH bits of {A, Q};
- enter DONE.
REQ-019 Latency SHALL be fixed: if start is accepted at edge t, done is high during the cycle following edge t+WIDTH+1, regardless of operand values or mode.
REQ-020 prod SHALL hold its value from the DONE entry until the next completion; it SHALL NOT change during IDLE or CALC.
REQ-021 start SHALL be ignored in CALC and DONE.
REQ-022 Operand or mode changes during CALC SHALL have no effect on the result in progress.
REQ-023 start held continuously high SHALL give back-to-back multiplies with one IDLE cycle between a DONE and the next CALC.
REQ-024 The result SHALL be exact for all operand pairs in both modes, including:
- signed: -2^(WIDTH-1) x -2^(WIDTH-1);
- unsigned: (2^WIDTH-1) x (2^WIDTH-1).

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL go to IDLE and clear prod, A, Q, q_m1, M and the counter to 0.
REQ-026 During and immediately after reset, outputs SHALL read ready=1, busy=0, done=0.
REQ-027 rst SHALL take priority over start; rst asserted during CALC or DONE SHALL abort the operation with no done pulse and prod=0.
REQ-028 A start presented on the first edge after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover these directed scenarios:
- Signed -128 x -128 (a=0x80, b=0x80, signed_mode=1) -> done exactly 9 cycles after the start edge; prod=0x4000.
- Unsigned 255 x 255 (a=0xFF, b=0xFF, signed_mode=0) -> prod=0xFE01; the same operands with signed_mode=1 (-1 x -1) -> prod=0x0001.
- Signed -1 x 127 (a=0xFF, b=0x7F) -> prod=0xFF81; 0 x 0x5A -> prod=0x0000.
- start pulsed, then a/b/start toggled randomly during CALC -> exactly one done; prod equals the originally sampled product.
- rst asserted at the 4th CALC cycle -> next cycle ready=1, busy=0, prod=0, no done; a following start 3x5 unsigned -> prod=0x000F.
- start held high with 7 x 9 -> done pulses every 11 cycles; prod=0x003F each time, with one ready cycle between each done and the next busy.
REQ-030 The bench SHALL run a random regression of at least 10000 operand/mode triples against a reference product, checking prod and done timing.
